// File: rtl/mini_cpu_param.sv
// Parametrised mini CPU: one instruction per accept; single-cycle ALU ops, DATA_W-cycle shift-add multiply.
// Back-pressure: In_ready drops for the whole multiply; Done pulses the cycle after retirement.
module mini_cpu_param #(
    parameter int DATA_W = 8,
    parameter int NREG   = 4,
    localparam int RW      = $clog2(NREG),
    localparam int INSTR_W = 4 + 2 * RW + DATA_W
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [INSTR_W-1:0] In,
    input  logic               In_valid,
    output logic               In_ready,
    output logic [DATA_W-1:0]  Out,
    output logic               Overflow,
    output logic               Busy,
    output logic               Done,
    input  logic [RW-1:0]      Dbg_sel,
    output logic [DATA_W-1:0]  Dbg_data
);

    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [3:0] OP_CLR = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_MOV = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;
    localparam logic [3:0] OP_SHL = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_OR  = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd8;
    localparam logic [3:0] OP_SUB = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t state, state_nxt;

    logic [3:0]          op;
    logic [RW-1:0]       rd, rs;
    logic [DATA_W-1:0]   imm, a, b;
    logic                accept, mul_last;
    logic [DATA_W-1:0]   regs [NREG];
    logic [CW-1:0]       cnt;
    logic [2*DATA_W-1:0] acc, acc_nxt, mcand;
    logic [DATA_W-1:0]   mplier;

    assign op       = In[INSTR_W-1 -: 4];
    assign rd       = In[INSTR_W-5 -: RW];
    assign rs       = In[INSTR_W-5-RW -: RW];
    assign imm      = In[DATA_W-1:0];
    assign a        = regs[rd];
    assign b        = regs[rs];
    assign accept   = In_valid & In_ready;
    assign Dbg_data = regs[Dbg_sel];
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge Clock) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        In_ready  = 1'b0;
        Busy      = 1'b0;
        mul_last  = 1'b0;
        case (state)
            S_IDLE: begin
                In_ready = 1'b1;
                if (In_valid && op == OP_MUL) state_nxt = S_MUL;
            end
            S_MUL: begin
                Busy = 1'b1;
                if (cnt == CW'(DATA_W - 1)) begin
                    mul_last  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            Out      <= '0;
            Overflow <= 1'b0;
            Done     <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else begin
            Done <= 1'b0;
            if (accept) begin
                Done <= (op != OP_MUL);
                case (op)
                    OP_CLR: begin
                        for (int i = 0; i < NREG; i++) regs[i] <= '0;
                        Out      <= '0;
                        Overflow <= 1'b0;
                    end
                    OP_LDI: regs[rd] <= imm;
                    OP_MOV: regs[rd] <= Out;
                    OP_ADD: {Overflow, Out} <= {1'b0, a} + {1'b0, b};
                    OP_SHL: begin
                        Out      <= {b[DATA_W-2:0], 1'b0};
                        Overflow <= b[DATA_W-1];
                    end
                    OP_SHR: begin
                        Out      <= {1'b0, b[DATA_W-1:1]};
                        Overflow <= 1'b0;
                    end
                    OP_AND: begin
                        Out      <= a & b;
                        Overflow <= 1'b0;
                    end
                    OP_OR: begin
                        Out      <= a | b;
                        Overflow <= 1'b0;
                    end
                    OP_CMP: begin
                        Out      <= (a < b) ? '1 : ((a == b) ? '0 : DATA_W'(1));
                        Overflow <= 1'b0;
                    end
                    OP_SUB: begin
                        Out      <= a - b;
                        Overflow <= (a < b);
                    end
                    OP_MUL: begin
                        // Operands captured here; the register file is not read again.
                        acc    <= '0;
                        mcand  <= {{DATA_W{1'b0}}, a};
                        mplier <= b;
                        cnt    <= '0;
                    end
                    default: ;
                endcase
            end else if (Busy) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + CW'(1);
                if (mul_last) begin
                    Out      <= acc_nxt[DATA_W-1:0];
                    Overflow <= |acc_nxt[2*DATA_W-1:DATA_W];
                    Done     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mini_cpu_param.sv
// Directed bench for mini_cpu_param; runs the same scenarios on an 8-bit/4-reg and a 16-bit/8-reg instance.
module tb_mini_cpu_param;

    localparam logic [3:0] CLR = 4'd0, LDI = 4'd1, MOV = 4'd2, ADD = 4'd3, SHL = 4'd4,
                           SHR = 4'd5, AND = 4'd6, OR = 4'd7, CMP = 4'd8, SUB = 4'd9,
                           MUL = 4'd10, NOP = 4'd12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, cfg;
    logic [2:0]  dbg_sel;
    logic [15:0] in8;
    logic        v8, rdy8, ov8, busy8, done8;
    logic [7:0]  out8, dbg8;
    logic [25:0] in16;
    logic        v16, rdy16, ov16, busy16, done16;
    logic [15:0] out16, dbg16;

    mini_cpu_param #(.DATA_W(8), .NREG(4)) dut8 (
        .Clock(clk), .Reset_n(rst_n), .In(in8), .In_valid(v8), .In_ready(rdy8),
        .Out(out8), .Overflow(ov8), .Busy(busy8), .Done(done8),
        .Dbg_sel(dbg_sel[1:0]), .Dbg_data(dbg8)
    );

    mini_cpu_param #(.DATA_W(16), .NREG(8)) dut16 (
        .Clock(clk), .Reset_n(rst_n), .In(in16), .In_valid(v16), .In_ready(rdy16),
        .Out(out16), .Overflow(ov16), .Busy(busy16), .Done(done16),
        .Dbg_sel(dbg_sel), .Dbg_data(dbg16)
    );

    logic [15:0] o_out, o_dbg;
    logic        o_ov, o_busy, o_rdy, o_done;
    assign o_out  = cfg ? out16  : {8'h00, out8};
    assign o_dbg  = cfg ? dbg16  : {8'h00, dbg8};
    assign o_ov   = cfg ? ov16   : ov8;
    assign o_busy = cfg ? busy16 : busy8;
    assign o_rdy  = cfg ? rdy16  : rdy8;
    assign o_done = cfg ? done16 : done8;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cfg %0d): got %0h expected %0h", tag, cfg, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic [15:0] v8w, input logic [15:0] v16w);
        return cfg ? v16w : v8w;
    endfunction

    function automatic int width();
        return cfg ? 16 : 8;
    endfunction

    function automatic int nreg();
        return cfg ? 8 : 4;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [15:0] imm);
        if (cfg) begin
            in16 = {op, rd, rs, imm};
            v16  = 1'b1;
        end else begin
            in8 = {op, rd[1:0], rs[1:0], imm[7:0]};
            v8  = 1'b1;
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [15:0] imm);
        @(negedge clk);
        drive(op, rd, rs, imm);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
    endtask

    task automatic rd_dbg(input int idx, output logic [15:0] val);
        dbg_sel = 3'(idx);
        #1;
        val = o_dbg;
    endtask

    task automatic ldi(input int rd, input logic [15:0] imm);
        logic [15:0] v;
        send(LDI, 3'(rd), 3'd0, imm);
        rd_dbg(rd, v);
        check("ldi", v, imm);
    endtask

    task automatic op1(input string tag, input logic [3:0] op, input logic [15:0] exp_out,
                       input logic exp_ov);
        send(op, 3'd0, 3'd1, 16'h0);
        check({tag, "_done"}, o_done, 1);
        check({tag, "_out"}, o_out, exp_out);
        check({tag, "_ov"}, o_ov, exp_ov);
    endtask

    task automatic check_regs_zero(input string tag);
        logic [15:0] v;
        for (int i = 0; i < nreg(); i++) begin
            rd_dbg(i, v);
            check(tag, v, 0);
        end
    endtask

    // Counts cycles with In_ready low after a MUL accept; leaves time at #1 after the retiring edge.
    task automatic wait_mul(input logic [15:0] prev_out, output int cycles, output int early);
        int held_bad = 0;
        cycles = 0;
        early  = 0;
        check("mul_busy", o_busy, 1);
        while (!o_rdy && cycles < 100) begin
            cycles++;
            if (o_done) early++;
            if (o_out !== prev_out) held_bad++;
            @(posedge clk);
            #1;
        end
        check("mul_out_held", held_bad, 0);
    endtask

    task automatic mul_test(input logic [15:0] prev_out, input logic [15:0] exp_out,
                            input logic exp_ov);
        int cycles, early;
        @(negedge clk);
        drive(MUL, 3'd0, 3'd1, 16'h0);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
        wait_mul(prev_out, cycles, early);
        check("mul_cycles", cycles, width());
        check("mul_no_early_done", early, 0);
        check("mul_done", o_done, 1);
        check("mul_out", o_out, exp_out);
        check("mul_ov", o_ov, exp_ov);
        @(posedge clk);
        #1;
        check("mul_done_single", o_done, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", o_out, 0);
        check("rst_ov", o_ov, 0);
        check("rst_busy", o_busy, 0);
        check("rst_rdy", o_rdy, 1);
        check("rst_done", o_done, 0);
        check_regs_zero("rst_regs");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_suite();
        logic [15:0] v;
        int cycles, early, ndone;
        do_reset();

        ldi(0, pk(16'h80, 16'h8000));
        ldi(1, pk(16'h82, 16'h8002));
        op1("shl", SHL, 16'h0004, 1'b1);
        op1("shr", SHR, pk(16'h41, 16'h4001), 1'b0);
        op1("and", AND, pk(16'h80, 16'h8000), 1'b0);
        op1("or",  OR,  pk(16'h82, 16'h8002), 1'b0);
        send(MOV, 3'd1, 3'd0, 16'h0);
        rd_dbg(1, v);
        check("mov_r1", v, pk(16'h82, 16'h8002));

        op1("cmp_lt", CMP, pk(16'hFF, 16'hFFFF), 1'b0);
        op1("sub_borrow", SUB, pk(16'hFE, 16'hFFFE), 1'b1);
        ldi(1, pk(16'h80, 16'h8000));
        op1("cmp_eq", CMP, 16'h0000, 1'b0);
        ldi(0, 16'h20);
        ldi(1, 16'h00);
        op1("cmp_gt", CMP, 16'h0001, 1'b0);

        ldi(0, 16'h55);
        ldi(1, 16'h01);
        op1("add", ADD, 16'h0056, 1'b0);
        ldi(0, pk(16'hFF, 16'hFFFF));
        op1("add_carry", ADD, 16'h0000, 1'b1);

        ldi(nreg() - 1, 16'h5A);
        ldi(2, 16'h21);
        send(ADD, 3'd2, 3'd2, 16'h0);
        check("add_same_reg", o_out, 16'h42);
        send(NOP, 3'd0, 3'd0, 16'h0);
        check("nop_done", o_done, 1);
        check("nop_out", o_out, 16'h42);

        ldi(0, 16'h0C);
        ldi(1, 16'h0B);
        mul_test(16'h42, 16'h84, 1'b0);
        ldi(0, pk(16'h20, 16'h2000));
        ldi(1, 16'h10);
        mul_test(16'h84, 16'h00, 1'b1);

        send(CLR, 3'd0, 3'd0, 16'h0);
        check("clr_out", o_out, 0);
        check("clr_ov", o_ov, 0);
        check_regs_zero("clr_regs");

        // An LDI held on In during a multiply must wait until the multiply retires.
        ldi(0, 16'h03);
        ldi(1, 16'h05);
        @(negedge clk);
        drive(MUL, 3'd0, 3'd1, 16'h0);
        @(posedge clk);
        #1;
        drive(LDI, 3'd2, 3'd0, 16'h33);
        wait_mul(16'h00, cycles, early);
        check("held_mul_cycles", cycles, width());
        check("held_mul_out", o_out, 16'h0F);
        rd_dbg(2, v);
        check("held_not_yet", v, 0);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
        check("held_done", o_done, 1);
        rd_dbg(2, v);
        check("held_ldi", v, 16'h33);

        // Reset three cycles into a multiply discards it.
        ldi(0, 16'h07);
        ldi(1, 16'h09);
        @(negedge clk);
        drive(MUL, 3'd0, 3'd1, 16'h0);
        @(posedge clk);
        #1;
        v8  = 1'b0;
        v16 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_rdy", o_rdy, 1);
        check("midrst_out", o_out, 0);
        check("midrst_ov", o_ov, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_regs_zero("midrst_regs");
        ndone = 0;
        repeat (width() + 4) begin
            @(posedge clk);
            #1;
            if (o_done) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_out_after", o_out, 0);
    endtask

    initial begin
        rst_n   = 1'b1;
        cfg     = 1'b0;
        dbg_sel = 3'd0;
        in8     = '0;
        v8      = 1'b0;
        in16    = '0;
        v16     = 1'b0;
        run_suite();
        cfg = 1'b1;
        run_suite();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mini_cpu_param.md
# mini_cpu_param

Parametrised next-generation mini CPU datapath: executes one instruction word per accepted handshake against an NREG-entry, DATA_W-bit register file, producing a result register (Out) and an Overflow flag. Extends the fixed 8-bit, two-register mini CPU in four ways:
- generic width and register count;
- valid/ready instruction handshake;
- subtract;
- multi-cycle shift-add multiply with busy back-pressure.

It sits between the instruction source (switch/tester or sequencer) and the display/output logic.

## Interface
- DATA_W, 8, datapath and register width (≥2)
- NREG, 4, register count (power of two, ≥2); RW = log2(NREG)
- INSTR_W (localparam), 4+2*RW+DATA_W, instruction width
- Clock  in  1  rising-edge clock
- Reset_n  in  1  synchronous, active-low reset
- In  in  INSTR_W  instruction: [INSTR_W-1 -: 4] opcode, then rd (RW bits), then rs (RW bits), [DATA_W-1:0] imm
- In_valid  in  1  instruction present
- In_ready  out  1  block can accept; low while multiply busy
- Out  out  DATA_W  result register
- Overflow  out  1  overflow/carry/borrow flag of last retired ALU op
- Busy  out  1  multiply in progress
- Done  out  1  one-cycle pulse on instruction retirement
- Dbg_sel  in  RW  register file debug select
- Dbg_data  out  DATA_W  combinational R[Dbg_sel]

## Operation
- Accept = In_valid & In_ready. Nothing changes on cycles with no accept (except multiply progress).
- Opcodes, with a = R[rd], b = R[rs]:
  - 0 CLR: all R, Out and Overflow ← 0.
  - 1 LDI: R[rd] ← imm.
  - 2 MOV: R[rd] ← Out.
  - 3 ADD: Out ← a+b; Overflow ← carry out.
  - 4 SHL: Out ← b<<1; Overflow ← b[MSB].
  - 5 SHR: Out ← b>>1 (logical); Overflow ← 0.
  - 6 AND, 7 OR: Out ← a&b / a|b; Overflow ← 0.
  - 8 CMP (unsigned): Out ← all-ones if a<b, 0 if equal, 1 if a>b; Overflow ← 0.
  - 9 SUB: Out ← a−b mod 2^DATA_W; Overflow ← borrow (a<b).
  - 10 MUL: Out ← low DATA_W bits of a×b; Overflow ← |(high DATA_W bits).
  - 11–15: NOP. Still accepted and Done pulses; no state change.
- LDI, MOV and CLR leave Overflow unchanged, except CLR, which zeroes it.
- rd == rs is legal everywhere.
- FSM states:
  - IDLE: In_ready = 1.
  - MUL: In_ready = 0, Busy = 1.
  - Transitions: IDLE → MUL on accepting opcode 10. MUL → IDLE after DATA_W iterations.
- Multiply implementation: operands are latched at accept; a 2*DATA_W-bit accumulator is updated by shift-add, one multiplier bit per cycle; the register file is not read again.
  - Register writes cannot occur during MUL, because no instruction is accepted.
  - MUL writes only Out and Overflow.
- Reset (Reset_n low at an edge), from any state including mid-multiply:
  - R, Out, Overflow, Busy and Done ← 0.
  - FSM ← IDLE; In_ready = 1 after that edge.
  - Any in-flight multiply is discarded.

## Timing
- Single-cycle ops accepted at edge k: Out, Overflow and R updated at edge k; Done high for cycle k→k+1.
- Back-to-back single-cycle ops: one per cycle. MOV immediately after ADD stores the new Out.
- MUL accepted at edge k:
  - Busy and !In_ready from edge k until edge k+DATA_W.
  - Out and Overflow are written at edge k+DATA_W and Done pulses for the cycle that follows it.
  - In_ready returns high after edge k+DATA_W, so the next accept can be at edge k+DATA_W+1.
  - Out holds its previous value throughout the multiply.
- In_valid during Busy is ignored. The source must hold the instruction until accepted.
- Dbg_data is combinational from the register file; it reflects a write at edge k from just after edge k.

## Test plan
- Reset: hold Reset_n low 2 cycles → Out = 0, Overflow = 0, Busy = 0, In_ready = 1, all Dbg_data = 0.
- Load, shift and logic (DATA_W = 8):
  - Stimulus: LDI R0 = 0x80, then LDI R1 = 0x82.
  - SHL rs = R1 → Out = 0x04, Overflow = 1.
  - SHR rs = R1 → Out = 0x41, Overflow = 0.
  - AND → Out = 0x80; OR → Out = 0x82.
  - Then MOV rd = R1 → Dbg_data(R1) = 0x82.
- Compare and subtract (rd = R0, rs = R1):
  - R0 = 0x80, R1 = 0x82: CMP → Out = 0xFF; SUB → Out = 0xFE, Overflow = 1.
  - R0 = R1 = 0x80: CMP → 0x00.
  - R0 = 0x20, R1 = 0x00: CMP → 0x01.
- Add carry: R0 = 0x55, R1 = 0x01 → Out = 0x56, Overflow = 0. R0 = 0xFF, R1 = 0x01 → Out = 0x00, Overflow = 1.
- Multiply:
  - R0 = 0x0C, R1 = 0x0B: MUL → In_ready low for exactly 8 cycles; then Out = 0x84, Overflow = 0, single Done pulse.
  - R0 = 0x20, R1 = 0x10: MUL → Out = 0x00, Overflow = 1.
  - An instruction held on In with In_valid during Busy is accepted only after completion.
- Reset mid-multiply: assert Reset_n low 3 cycles after a MUL accept → Busy = 0, Out = 0, registers = 0, no Done pulse. Repeat all scenarios with DATA_W = 16, NREG = 8.
